// File: rtl/lc2k_pkg.sv
// +--------------------------------------------------------------------+
// | lc2k_pkg: shared opcodes, instruction field positions and the       |
// | fetch controller state encoding for the LC2K front end.             |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package lc2k_pkg;

  localparam logic [2:0] c_OP_ADD  = 3'd0;
  localparam logic [2:0] c_OP_NOR  = 3'd1;
  localparam logic [2:0] c_OP_LW   = 3'd2;
  localparam logic [2:0] c_OP_SW   = 3'd3;
  localparam logic [2:0] c_OP_BEQ  = 3'd4;
  localparam logic [2:0] c_OP_JALR = 3'd5;
  localparam logic [2:0] c_OP_HALT = 3'd6;
  localparam logic [2:0] c_OP_NOOP = 3'd7;

  localparam int c_OPC_MSB  = 24;
  localparam int c_OPC_LSB  = 22;
  localparam int c_RA_MSB   = 21;
  localparam int c_RA_LSB   = 19;
  localparam int c_RB_MSB   = 18;
  localparam int c_RB_LSB   = 16;
  localparam int c_DEST_MSB = 2;
  localparam int c_DEST_LSB = 0;
  localparam int c_OFF_MSB  = 15;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT_I = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    UPDATE = 3'd5,
    HALT   = 3'd6
  } state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lc2k_inst_decode.sv
// +--------------------------------------------------------------------+
// | lc2k_inst_decode: combinational field extraction and write-back     |
// | select decode for one LC2K instruction word.                        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module lc2k_inst_decode
  import lc2k_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [2:0]  o_opcode,
  output logic [2:0]  o_reg_a,
  output logic [2:0]  o_reg_b,
  output logic [2:0]  o_dest,
  output logic [31:0] o_offset_ext,
  output logic        o_writes_reg,
  output logic        o_wb_sel_pc
);

  logic [2:0] w_op;
  logic       w_unused_hi;

  assign w_op         = i_ir[c_OPC_MSB:c_OPC_LSB];
  assign o_opcode     = w_op;
  assign o_reg_a      = i_ir[c_RA_MSB:c_RA_LSB];
  assign o_reg_b      = i_ir[c_RB_MSB:c_RB_LSB];
  assign o_offset_ext = sext16(i_ir[c_OFF_MSB:0]);
  assign w_unused_hi  = ^i_ir[31:c_OPC_MSB+1];

  always_comb begin
    o_writes_reg = 1'b0;
    o_wb_sel_pc  = 1'b0;
    o_dest       = i_ir[c_RB_MSB:c_RB_LSB];
    case (w_op)
      c_OP_ADD, c_OP_NOR: begin
        o_writes_reg = 1'b1;
        o_dest       = i_ir[c_DEST_MSB:c_DEST_LSB];
      end
      c_OP_LW:   o_writes_reg = 1'b1;
      c_OP_JALR: begin
        o_writes_reg = 1'b1;
        o_wb_sel_pc  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lc2k_fetch_ctrl.sv
// +--------------------------------------------------------------------+
// | lc2k_fetch_ctrl: multi-cycle fetch/decode/sequencing controller.    |
// | Optional retired-instruction counter: define LC2K_INST_COUNT_EN.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module lc2k_fetch_ctrl
  import lc2k_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [2:0]          read_regA,
  output logic [2:0]          read_regB,
  output logic [2:0]          write_reg,
  output logic [2:0]          opcode,
  output logic [31:0]         offset_ext,
  output logic                ex_start,
  input  logic                ex_done,
  input  logic                ex_eq,
  input  logic [PC_WIDTH-1:0] ex_target,
  output logic                reg_write_en,
  output logic                wb_sel_pc,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
`ifdef LC2K_INST_COUNT_EN
  ,
  output logic [31:0]         inst_count
`endif
);

  localparam logic [PC_WIDTH-1:0] c_PC_ONE = 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_ir;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_target;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic                r_req;
  logic                r_eq;
  logic                r_halted;
  logic                w_writes_reg;

  lc2k_inst_decode u_decode (
    .i_ir         (r_ir),
    .o_opcode     (opcode),
    .o_reg_a      (read_regA),
    .o_reg_b      (read_regB),
    .o_dest       (write_reg),
    .o_offset_ext (offset_ext),
    .o_writes_reg (w_writes_reg),
    .o_wb_sel_pc  (wb_sel_pc)
  );

  // Reset gates the request combinationally so a pending fetch drops at once.
  assign imem_req  = r_req & ~reset;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign halted    = r_halted;

  always_comb begin
    w_state_nxt  = r_state;
    ex_start     = 1'b0;
    reg_write_en = 1'b0;
    case (r_state)
      FETCH:  w_state_nxt = WAIT_I;
      WAIT_I: if (imem_ack) w_state_nxt = DECODE;
      DECODE: begin
        if (opcode == c_OP_HALT) begin
          w_state_nxt = HALT;
        end else if (opcode == c_OP_NOOP) begin
          w_state_nxt = UPDATE;
        end else begin
          w_state_nxt = EXEC;
          ex_start    = 1'b1;
        end
      end
      EXEC:   if (ex_done) w_state_nxt = WB;
      WB: begin
        reg_write_en = w_writes_reg;
        w_state_nxt  = UPDATE;
      end
      UPDATE: w_state_nxt = FETCH;
      HALT:   w_state_nxt = HALT;
      default: w_state_nxt = FETCH;
    endcase
  end

  // Offset is truncated to the PC width so branch wrap-around is modular.
  always_comb begin
    w_pc_inc = r_pc + c_PC_ONE;
    w_pc_nxt = w_pc_inc;
    if (opcode == c_OP_BEQ && r_eq) begin
      w_pc_nxt = w_pc_inc + offset_ext[PC_WIDTH-1:0];
    end else if (opcode == c_OP_JALR) begin
      w_pc_nxt = r_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_ir     <= '0;
      r_pc     <= RESET_PC;
      r_target <= '0;
      r_req    <= 1'b0;
      r_eq     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        FETCH:  r_req <= 1'b1;
        WAIT_I: if (imem_ack) begin
          r_ir  <= imem_rdata;
          r_req <= 1'b0;
        end
        DECODE: if (opcode == c_OP_HALT) r_halted <= 1'b1;
        EXEC:   if (ex_done) begin
          r_eq     <= ex_eq;
          r_target <= ex_target;
        end
        UPDATE: r_pc <= w_pc_nxt;
        default: ;
      endcase
    end
  end

`ifdef LC2K_INST_COUNT_EN
  logic [31:0] r_inst_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_count <= '0;
    end else if (r_state == UPDATE || (r_state == DECODE && opcode == c_OP_HALT)) begin
      r_inst_count <= r_inst_count + 32'd1;
    end
  end

  assign inst_count = r_inst_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lc2k_fetch_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_lc2k_fetch_ctrl: directed + randomized self-checking bench for   |
// | lc2k_fetch_ctrl, 16-bit and 4-bit PC instances in lockstep.         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_lc2k_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ex_done;
  logic        ex_eq;
  logic [15:0] ex_target;

  logic        imem_req, ex_start, reg_write_en, wb_sel_pc, halted;
  logic [15:0] imem_addr, pc;
  logic [2:0]  read_regA, read_regB, write_reg, opcode;
  logic [31:0] offset_ext;

  logic        imem_req4, ex_start4, reg_write_en4, wb_sel_pc4, halted4;
  logic [3:0]  imem_addr4, pc4;
  logic [2:0]  read_regA4, read_regB4, write_reg4, opcode4;
  logic [31:0] offset_ext4;
`ifdef LC2K_INST_COUNT_EN
  logic [31:0] inst_count, inst_count4;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_count = 32'd0;

  always #5 clk = ~clk;

  lc2k_fetch_ctrl #(.PC_WIDTH(16), .RESET_PC(16'd0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .read_regA(read_regA),
    .read_regB(read_regB), .write_reg(write_reg), .opcode(opcode),
    .offset_ext(offset_ext), .ex_start(ex_start), .ex_done(ex_done),
    .ex_eq(ex_eq), .ex_target(ex_target), .reg_write_en(reg_write_en),
    .wb_sel_pc(wb_sel_pc), .pc(pc), .halted(halted)
`ifdef LC2K_INST_COUNT_EN
    , .inst_count(inst_count)
`endif
  );

  lc2k_fetch_ctrl #(.PC_WIDTH(4), .RESET_PC(4'd0)) dut4 (
    .clk(clk), .reset(reset), .imem_req(imem_req4), .imem_addr(imem_addr4),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .read_regA(read_regA4),
    .read_regB(read_regB4), .write_reg(write_reg4), .opcode(opcode4),
    .offset_ext(offset_ext4), .ex_start(ex_start4), .ex_done(ex_done),
    .ex_eq(ex_eq), .ex_target(ex_target[3:0]), .reg_write_en(reg_write_en4),
    .wb_sel_pc(wb_sel_pc4), .pc(pc4), .halted(halted4)
`ifdef LC2K_INST_COUNT_EN
    , .inst_count(inst_count4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge that put the DUTs into FETCH.
  task automatic run_instr(input logic [31:0] ir, input int ack_dly, input int done_dly,
                           input logic eq, input logic [15:0] tgt);
    logic [2:0]  e_op, e_ra, e_rb, e_dest;
    logic [31:0] e_off;
    logic        e_wr;
    e_op   = 3'((ir >> 22) & 32'h7);
    e_ra   = 3'((ir >> 19) & 32'h7);
    e_rb   = 3'((ir >> 16) & 32'h7);
    e_off  = ((ir & 32'hFFFF) >= 32'h8000) ? ((ir & 32'hFFFF) - 32'h10000) : (ir & 32'hFFFF);
    e_wr   = (e_op == 3'd0 || e_op == 3'd1 || e_op == 3'd2 || e_op == 3'd5);
    e_dest = (e_op <= 3'd1) ? 3'(ir & 32'h7) : e_rb;

    chk("req_in_fetch", 32'(imem_req), 32'd0);
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    step();
    chk("req_wait", 32'({imem_req, imem_req4}), 32'd3);
    chk("addr", 32'(imem_addr), {16'd0, m_pc[15:0]});
    imem_ack = 1'b0;
    repeat (ack_dly) step();
    chk("req_hold", 32'(imem_req), 32'd1);
    chk("addr4", 32'(imem_addr4), {28'd0, m_pc[3:0]});
    imem_ack   = 1'b1;
    imem_rdata = ir;
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("req_drop", 32'(imem_req), 32'd0);
    chk("dec_regs", {20'd0, read_regA, read_regB, opcode, 3'd0}, {20'd0, e_ra, e_rb, e_op, 3'd0});
    chk("dec_off", offset_ext, e_off);
    chk("dec4_regs", {20'd0, read_regA4, read_regB4, opcode4, 3'd0}, {20'd0, e_ra, e_rb, e_op, 3'd0});
    chk("dec4_off", offset_ext4, e_off);

    if (e_op == 3'd6) begin
      chk("halt_no_start", 32'(ex_start), 32'd0);
      step();
      m_count = m_count + 32'd1;
      chk("halted", 32'({halted, halted4}), 32'd3);
      chk("halt_pc", 32'(pc), {16'd0, m_pc[15:0]});
      chk("halt_pc4", 32'(pc4), {28'd0, m_pc[3:0]});
    end else if (e_op == 3'd7) begin
      chk("noop_no_start", 32'({ex_start, ex_start4}), 32'd0);
      step();
      chk("noop_no_we", 32'(reg_write_en), 32'd0);
      step();
      m_pc    = m_pc + 32'd1;
      m_count = m_count + 32'd1;
      chk("pc", 32'(pc), {16'd0, m_pc[15:0]});
      chk("pc4", 32'(pc4), {28'd0, m_pc[3:0]});
    end else begin
      chk("ex_start", 32'({ex_start, ex_start4}), 32'd3);
      ex_done   = 1'($urandom_range(0, 1));
      ex_eq     = ~eq;
      ex_target = ~tgt;
      step();
      chk("ex_start_pulse", 32'(ex_start), 32'd0);
      ex_done = 1'b0;
      repeat (done_dly) step();
      chk("we_before_done", 32'(reg_write_en), 32'd0);
      ex_done   = 1'b1;
      ex_eq     = eq;
      ex_target = tgt;
      step();
      ex_done   = 1'b0;
      ex_eq     = 1'($urandom_range(0, 1));
      ex_target = 16'($urandom);
      chk("we_wb", 32'({reg_write_en, reg_write_en4}), e_wr ? 32'd3 : 32'd0);
      chk("wb_sel_pc", 32'({wb_sel_pc, wb_sel_pc4}), (e_op == 3'd5) ? 32'd3 : 32'd0);
      if (e_wr) chk("write_reg", 32'({write_reg, write_reg4}), 32'({e_dest, e_dest}));
      step();
      chk("we_one_cycle", 32'(reg_write_en), 32'd0);
      step();
      if (e_op == 3'd4 && eq) m_pc = m_pc + 32'd1 + e_off;
      else if (e_op == 3'd5)  m_pc = {16'd0, tgt};
      else                    m_pc = m_pc + 32'd1;
      m_count = m_count + 32'd1;
      chk("pc", 32'(pc), {16'd0, m_pc[15:0]});
      chk("pc4", 32'(pc4), {28'd0, m_pc[3:0]});
    end
  endtask

  initial begin
    logic [31:0] ir;
    logic [2:0]  rop;
    int          req_seen;
    int          strobe_seen;

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    ex_done = 1'b0; ex_eq = 1'b0; ex_target = '0;
    repeat (3) step();
    chk("rst_ctrl", 32'({imem_req, ex_start, reg_write_en, wb_sel_pc, halted}), 32'd0);
    chk("rst_pc", 32'({pc, 12'd0, pc4}), 32'd0);
    chk("rst_fields", {write_reg, read_regA, read_regB, opcode, 20'd0}, 32'd0);
    chk("rst_off", offset_ext, 32'd0);
`ifdef LC2K_INST_COUNT_EN
    chk("rst_count", inst_count, 32'd0);
`endif

    reset = 1'b0;
    step();
    chk("first_req", 32'(imem_req), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_mid_wait_req", 32'(imem_req), 32'd0);
    chk("rst_mid_wait_pc", 32'(pc), 32'd0);
    reset = 1'b0;

    run_instr(32'h000A0003, 0, 2, 1'b0, 16'h0);
    repeat (4) run_instr(32'h01C00000, 0, 0, 1'b0, 16'h0);
    run_instr(32'h0109FFFF, 1, 0, 1'b1, 16'h0);
    run_instr(32'h0109FFFF, 0, 1, 1'b0, 16'h0);
    run_instr(32'h01C00000, 2, 0, 1'b0, 16'h0);
    run_instr(32'h01650000, 0, 0, 1'b1, 16'h0020);
    run_instr(32'h01650000, 0, 0, 1'b0, 16'h000F);
    run_instr(32'h01C00000, 0, 0, 1'b0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      ir  = $urandom;
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'd6) rop = 3'd7;
      ir[24:22] = rop;
      run_instr(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 16'($urandom));
    end

    run_instr(32'h01650000, 0, 0, 1'b0, 16'h0003);
    run_instr(32'h01800000, 0, 0, 1'b0, 16'h0);
    req_seen = 0;
    strobe_seen = 0;
    for (int i = 0; i < 100; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      ex_done    = 1'($urandom_range(0, 1));
      step();
      if (imem_req || imem_req4) req_seen++;
      if (reg_write_en || ex_start) strobe_seen++;
    end
    imem_ack = 1'b0;
    ex_done  = 1'b0;
    chk("halt_no_req", 32'(req_seen), 32'd0);
    chk("halt_no_strobe", 32'(strobe_seen), 32'd0);
    chk("halt_pc_stays", 32'(pc), 32'd3);
    chk("halt_sticky", 32'(halted), 32'd1);
`ifdef LC2K_INST_COUNT_EN
    chk("inst_count", inst_count, m_count);
`endif

    reset = 1'b1;
    step();
    reset = 1'b0;
    m_pc = 32'd0;
    chk("rst_clears_halt", 32'({halted, halted4, imem_req}), 32'd0);
    chk("rst_pc_again", 32'(pc), 32'd0);
    run_instr(32'h01C00000, 0, 0, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lc2k_fetch_ctrl.md
Name: lc2k_fetch_ctrl

Overview:
- Multi-cycle fetch/decode/sequencing controller for the LC2K single-cycle CPU.
- Sits directly upstream of the register file. It fetches an instruction over a request/ack memory handshake, decodes fields, and drives register-file read/write selects.
- Waits for execute completion, then issues a single-cycle write-enable pulse and updates the PC.
- Write-enable is asserted only after the result is valid, which removes the add/nor destReg==regA/regB write-before-compute hazard.

Parameters:
- PC_WIDTH, 16, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction fetch request; held until imem_ack.
- imem_addr  output  PC_WIDTH  fetch address, equal to PC.
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  32  instruction word.
- read_regA  output  3  regA field, bits 21:19.
- read_regB  output  3  regB field, bits 18:16.
- write_reg  output  3  write-back destination select.
- opcode  output  3  decoded opcode, bits 24:22.
- offset_ext  output  32  sign-extended bits 15:0.
- ex_start  output  1  one-cycle pulse that starts execute.
- ex_done  input  1  execute result valid.
- ex_eq  input  1  regA==regB compare result, sampled with ex_done.
- ex_target  input  PC_WIDTH  jalr target (regA value), sampled with ex_done.
- reg_write_en  output  1  one-cycle register-file write strobe.
- wb_sel_pc  output  1  write-back value select: 1 = PC+1 (jalr), 0 = ALU/memory result.
- pc  output  PC_WIDTH  current PC.
- halted  output  1  sticky after halt.

Behaviour:
- Reset values: pc=RESET_PC; state=FETCH; all other outputs 0.
- Reset has priority in every state, including mid-handshake. An outstanding imem_req is dropped in the same cycle.
- States and transitions:
  - FETCH: assert imem_req; go to WAIT_I.
  - WAIT_I: hold imem_req and imem_addr stable. On imem_ack, latch imem_rdata into the instruction register (IR), deassert req, go to DECODE.
  - DECODE: read_regA, read_regB, opcode and offset_ext are driven from IR and held stable until the next DECODE.
    - halt (6): set halted, go to HALT; PC unchanged.
    - noop (7): go to UPDATE.
    - otherwise: pulse ex_start, go to EXEC.
  - EXEC: wait for ex_done. ex_done arriving in the same cycle as ex_start is ignored; the earliest accepted ex_done is the cycle after entry. On ex_done, latch ex_eq and ex_target, go to WB.
  - WB: pulse reg_write_en for exactly 1 cycle for add, nor, lw, jalr; no pulse for sw, beq. Go to UPDATE.
    - write_reg = IR[2:0] for add/nor; IR[18:16] for lw/jalr.
    - wb_sel_pc = 1 only for jalr.
  - UPDATE: compute next PC, go to FETCH.
    - beq taken: PC = PC+1+offset.
    - jalr: PC = ex_target.
    - otherwise: PC = PC+1.
  - HALT: absorbing until reset. No requests, no strobes.
- PC arithmetic is modulo 2^PC_WIDTH. The offset is truncated to PC_WIDTH before adding, so wrap-around is silent.
- jalr with regA==regB writes PC+1 and jumps to the old regA value, because ex_target is latched before write-back.
- imem_ack outside WAIT_I is ignored. ex_done outside EXEC is ignored.
- Minimum instruction latency: 6 cycles for add, nor, lw, sw, beq, jalr (ack and ex_done one cycle after request/start). noop takes 4 cycles.

Optional Feature:
- Macro LC2K_INST_COUNT_EN.
- When defined, adds output inst_count [31:0]. It resets to 0 and increments by 1 in each UPDATE cycle; halt is counted once on entry to HALT. It wraps at 2^32.
- When undefined, the port and counter are absent.

Decomposition:
- Shared package lc2k_pkg holds:
  - opcode constants ADD=0, NOR=1, LW=2, SW=3, BEQ=4, JALR=5, HALT=6, NOOP=7;
  - field bit-position constants;
  - the state enum FETCH/WAIT_I/DECODE/EXEC/WB/UPDATE/HALT.
- One combinational sub-module, lc2k_inst_decode. It maps IR to field selects, sign-extended offset, writes_reg flag, wb_sel_pc and dest-select. The controller keeps the FSM and PC.

Test Plan:
- Reset mid-WAIT_I, imem_ack never given → next cycle imem_req=0, pc=0, state FETCH.
- IR=0x000A0003 (add r1,r2→r3), ex_done 3 cycles after ex_start:
  - read_regA=1, read_regB=2;
  - reg_write_en high exactly 1 cycle with write_reg=3, after ex_done;
  - pc 0→1.
- beq r1,r1,offset=-1 (IR=0x0109FFFF) at pc=5 with ex_eq=1 → pc=5; with ex_eq=0 → pc=6; no reg_write_en in either case.
- jalr r4,r5 (IR=0x01650000) at pc=7, ex_target=0x20:
  - write_reg=5, wb_sel_pc=1, reg_write_en pulsed;
  - pc=0x20.
- halt at pc=3 → halted=1, pc stays 3, no further imem_req for 100 cycles. With LC2K_INST_COUNT_EN and 3 prior instructions, inst_count=4.
- PC_WIDTH=4, pc=15, noop → pc wraps to 0.
